// File: rtl/msrv_32_iadder_queue_if.sv
// Bundle of the operand/result handshake signals of the address-adder queue.
// The producer/consumer side uses "master", the queue itself uses "slave".
interface msrv_32_iadder_queue_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush_in;
    logic             valid_in;
    logic             ready_out;
    logic [1:0]       iadder_src_in;
    logic [XLEN-1:0]  rs_1_in;
    logic [XLEN-1:0]  pc_in;
    logic [XLEN-1:0]  imm_in;
    logic             valid_out;
    logic             ready_in;
    logic [XLEN-1:0]  iadder_out;
    logic             misaligned_out;
    logic             carry_out;
    logic [CNT_W-1:0] op_count_out;

    modport master (
        output flush_in, valid_in, iadder_src_in, rs_1_in, pc_in, imm_in, ready_in,
        input  ready_out, valid_out, iadder_out, misaligned_out, carry_out, op_count_out
    );

    modport slave (
        input  flush_in, valid_in, iadder_src_in, rs_1_in, pc_in, imm_in, ready_in,
        output ready_out, valid_out, iadder_out, misaligned_out, carry_out, op_count_out
    );
endinterface

// File: rtl/msrv_32_iadder_queue.sv
// Branch/jump target adder feeding a small FIFO of {sum, carry, misaligned}.
// The sum is formed at push time; the head entry drives the outputs, which are
// forced to zero whenever the queue is empty.
module msrv_32_iadder_queue #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,
    parameter int IALIGN_BITS = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_n_in,
    msrv_32_iadder_queue_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            EW       = XLEN + 2;
    localparam logic [PW:0]   OCC_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry layout: {sum[XLEN-1:0], carry, misaligned}
    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;   // low during reset, high from the first edge after release

    logic [XLEN-1:0]  base, addend, sum_masked;
    logic [XLEN:0]    sum_full;
    logic             mis;
    logic             ready, valid, push, pop;
    logic [EW-1:0]    head;

    // Operand selection, add, JALR bit-0 clear and alignment check.
    always_comb begin
        base   = bus.pc_in;
        addend = bus.imm_in;
        case (bus.iadder_src_in)
            2'b01, 2'b10: base   = bus.rs_1_in;
            2'b11:        addend = XLEN'(4);
            default:      ;
        endcase
        sum_full   = {1'b0, base} + {1'b0, addend};
        sum_masked = sum_full[XLEN-1:0];
        if (bus.iadder_src_in == 2'b10) begin
            sum_masked[0] = 1'b0;   // carry still comes from the unmasked add
        end
        mis = |sum_masked[IALIGN_BITS-1:0];
    end

    // Handshake: readiness looks only at registered state and flush.
    always_comb begin
        ready = run_q && (occ_q != OCC_FULL) && !bus.flush_in;
        valid = (occ_q != '0);
        push  = bus.valid_in && ready;
        pop   = valid && bus.ready_in;
    end

    // Pointer, occupancy and counter next-state; flush overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (bus.flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: ;
            endcase
        end
    end

    // Control state with asynchronous reset; entries themselves are not reset.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
        end
    end

    // Entry storage written at push time.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sum_masked, sum_full[XLEN], mis};
        end
    end

    // Head entry drives the outputs, zeroed while empty.
    always_comb begin
        head               = valid ? mem_q[rd_ptr_q] : '0;
        bus.ready_out      = ready;
        bus.valid_out      = valid;
        bus.iadder_out     = head[EW-1:2];
        bus.carry_out      = head[1];
        bus.misaligned_out = head[0];
        bus.op_count_out   = cnt_q;
    end
endmodule

// File: tb/tb_msrv_32_iadder_queue.sv
// Bench for msrv_32_iadder_queue: two instances (IALIGN_BITS=2/CNT_W=16 and
// IALIGN_BITS=1/CNT_W=4) share clock, reset and stimulus. Expected results come
// from a hand-computed vector table and are tracked in a scoreboard queue.
module tb_msrv_32_iadder_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush_r, valid_r, ready_r;
    logic [1:0]  mode_r;
    logic [31:0] rs1_r, pc_r, imm_r;
    int          cur;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] rs1, pc, imm, sum;
        logic        carry, mis2, mis1;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        carry, mis2, mis1;
    } exp_t;

    vec_t  vecs [9];
    exp_t  exp_q [$];
    int    tests = 0;
    int    fails = 0;
    bit    run_m;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    msrv_32_iadder_queue_if #(.XLEN(32), .CNT_W(16)) bus0 ();
    msrv_32_iadder_queue_if #(.XLEN(32), .CNT_W(4))  bus1 ();

    assign bus0.flush_in      = flush_r;
    assign bus0.valid_in      = valid_r;
    assign bus0.ready_in      = ready_r;
    assign bus0.iadder_src_in = mode_r;
    assign bus0.rs_1_in       = rs1_r;
    assign bus0.pc_in         = pc_r;
    assign bus0.imm_in        = imm_r;
    assign bus1.flush_in      = flush_r;
    assign bus1.valid_in      = valid_r;
    assign bus1.ready_in      = ready_r;
    assign bus1.iadder_src_in = mode_r;
    assign bus1.rs_1_in       = rs1_r;
    assign bus1.pc_in         = pc_r;
    assign bus1.imm_in        = imm_r;

    msrv_32_iadder_queue #(.XLEN(32), .DEPTH(4), .IALIGN_BITS(2), .CNT_W(16)) dut0 (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .bus                    (bus0)
    );

    msrv_32_iadder_queue #(.XLEN(32), .DEPTH(4), .IALIGN_BITS(1), .CNT_W(4)) dut1 (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .bus                    (bus1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        cur    = i;
        mode_r = vecs[i].mode;
        rs1_r  = vecs[i].rs1;
        pc_r   = vecs[i].pc;
        imm_r  = vecs[i].imm;
    endtask

    // Compare both instances against the scoreboard head and model state.
    task automatic check_outputs();
        exp_t h;
        bit   ne;
        bit   rdy;
        ne  = (exp_q.size() != 0);
        rdy = run_m && (exp_q.size() < 4) && !flush_r;
        h.sum = '0; h.carry = 1'b0; h.mis2 = 1'b0; h.mis1 = 1'b0;
        if (ne) h = exp_q[0];
        chk("valid0", 64'(bus0.valid_out), 64'(ne));
        chk("valid1", 64'(bus1.valid_out), 64'(ne));
        chk("ready0", 64'(bus0.ready_out), 64'(rdy));
        chk("ready1", 64'(bus1.ready_out), 64'(rdy));
        chk("sum0",   64'(bus0.iadder_out), 64'(h.sum));
        chk("sum1",   64'(bus1.iadder_out), 64'(h.sum));
        chk("carry0", 64'(bus0.carry_out), 64'(h.carry));
        chk("carry1", 64'(bus1.carry_out), 64'(h.carry));
        chk("mis0",   64'(bus0.misaligned_out), 64'(h.mis2));
        chk("mis1",   64'(bus1.misaligned_out), 64'(h.mis1));
        chk("cnt0",   64'(bus0.op_count_out), 64'(cnt0));
        chk("cnt1",   64'(bus1.op_count_out), 64'(cnt1));
        if (ne && ready_r)
            $display("[TB] pop sum=0x%08h carry=%0b mis=%0b/%0b", h.sum, h.carry, h.mis2, h.mis1);
    endtask

    // One clock: check at negedge, then advance the model across the posedge.
    task automatic step();
        bit   push, pop;
        exp_t e;
        @(negedge clk);
        check_outputs();
        push = valid_r && run_m && (exp_q.size() < 4) && !flush_r;
        pop  = (exp_q.size() != 0) && ready_r;
        @(posedge clk);
        if (rst_n === 1'b1) begin
            if (flush_r) begin
                exp_q.delete();
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (push) begin
                    e.sum = vecs[cur].sum; e.carry = vecs[cur].carry;
                    e.mis2 = vecs[cur].mis2; e.mis1 = vecs[cur].mis1;
                    exp_q.push_back(e);
                end
            end
            if (push) begin
                cnt0 = cnt0 + 16'd1;
                cnt1 = cnt1 + 4'd1;
            end
        end
        run_m = (rst_n === 1'b1);
        #1;
    endtask

    initial begin
        //          mode   rs1           pc            imm           sum           c  m2 m1
        vecs[0] = '{2'b00, 32'h0,        32'h1000,     32'hFFFFFFF0, 32'h00000FF0, 1, 0, 0};
        vecs[1] = '{2'b10, 32'h2003,     32'h0,        32'h0,        32'h00002002, 0, 1, 0};
        vecs[2] = '{2'b01, 32'h10,       32'h500,      32'h4,        32'h00000014, 0, 0, 0};
        vecs[3] = '{2'b11, 32'h0,        32'hFFFFFFFC, 32'h123,      32'h00000000, 1, 0, 0};
        vecs[4] = '{2'b11, 32'h0,        32'h1002,     32'h0,        32'h00001006, 0, 1, 0};
        vecs[5] = '{2'b01, 32'hFFFFFFFF, 32'h0,        32'h1,        32'h00000000, 1, 0, 0};
        vecs[6] = '{2'b10, 32'hFFFFFFFF, 32'h0,        32'h2,        32'h00000000, 1, 0, 0};
        vecs[7] = '{2'b00, 32'h100,      32'h7,        32'h0,        32'h00000007, 0, 1, 1};
        vecs[8] = '{2'b01, 32'h1,        32'hFF,       32'h1,        32'h00000002, 0, 1, 0};

        rst_n = 1'b0; flush_r = 1'b0; valid_r = 1'b0; ready_r = 1'b0;
        run_m = 1'b0; cnt0 = '0; cnt1 = '0;
        drive(0);
        #1;
        step(); step();
        rst_n = 1'b1;     // released between edges; takes effect at next posedge
        step();

        // Streaming through the vector table, one push and one pop per cycle.
        for (int i = 0; i < 9; i++) begin
            drive(i); valid_r = 1'b1; ready_r = 1'b1;
            step();
        end
        valid_r = 1'b0;
        step(); step();

        // Fill to DEPTH with the consumer stalled; the fifth push is refused.
        ready_r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i); valid_r = 1'b1;
            step();
        end
        chk("full_ready", 64'(bus0.ready_out), 64'd0);
        chk("full_cnt",   64'(bus0.op_count_out), 64'd13);
        valid_r = 1'b0; ready_r = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Occupancy 2, simultaneous push/pop, then flush with valid_in high.
        ready_r = 1'b0; valid_r = 1'b1;
        drive(5); step();
        drive(6); step();
        drive(7); ready_r = 1'b1; step();
        drive(8); flush_r = 1'b1; step();
        flush_r = 1'b0; valid_r = 1'b0;
        step();
        chk("flush_cnt", 64'(bus0.op_count_out), 64'd16);

        // Asynchronous reset with three entries queued.
        ready_r = 1'b0; valid_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i); step();
        end
        valid_r = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid0", 64'(bus0.valid_out), 64'd0);
        chk("arst_valid1", 64'(bus1.valid_out), 64'd0);
        chk("arst_cnt0",   64'(bus0.op_count_out), 64'd0);
        chk("arst_cnt1",   64'(bus1.op_count_out), 64'd0);
        chk("arst_ready",  64'(bus0.ready_out), 64'd0);
        chk("arst_sum",    64'(bus0.iadder_out), 64'd0);
        exp_q.delete(); cnt0 = '0; cnt1 = '0; run_m = 1'b0;
        #1 rst_n = 1'b1;
        step();
        drive(3); valid_r = 1'b1; ready_r = 1'b1;
        step();
        valid_r = 1'b0;
        step(); step();

        // Counter wrap on the 4-bit instance: 16 more pushes make 17 total.
        valid_r = 1'b1; ready_r = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(k % 9); step();
        end
        valid_r = 1'b0;
        chk("wrap_cnt1", 64'(bus1.op_count_out), 64'd1);
        chk("wrap_cnt0", 64'(bus0.op_count_out), 64'd17);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
